// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl: capture sequencer and round-robin read arbiter for the
// sample_storage buffer. Optional build macro: CAP_TIMEOUT_EN enables an
// in_valid gap timeout that returns ARM/CAPTURE to IDLE.
module sample_capture_ctrl #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SKIP    = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              store_en,
    output logic [ADDR_W-1:0] wr_count,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              gnt_b,
    output logic              stor_read,
    output logic [ADDR_W-1:0] stor_addr,
    input  logic [DATA_W-1:0] stor_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid_a,
    output logic              rd_valid_b
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

    localparam state_t          ENTRY     = (SKIP == 0) ? S_CAPTURE : S_ARM;
    localparam logic [15:0]     SKIP_LAST = (SKIP == 0) ? 16'd0 : 16'(SKIP - 1);
    localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    state_t      state, state_nxt;
    logic [15:0] skip_cnt;
    logic        cap_start;
    logic        timeout_hit;
    logic        last_b;
    logic        rd_oob;
    logic        grant_ok, elig_a, elig_b, pick_a, pick_b;

    assign busy      = (state == S_ARM) || (state == S_CAPTURE);
    assign done      = (state == S_DONE);
    assign cap_start = start && !abort && ((state == S_IDLE) || (state == S_DONE));

`ifdef CAP_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
    logic [GAP_W-1:0] gap_cnt;

    assign timeout_hit = busy && !in_valid && (gap_cnt == GAP_W'(TIMEOUT - 1));

    // Gap counter: cycles without in_valid while armed or capturing
    always_ff @(posedge clk) begin
        if (rst || cap_start || in_valid || !busy) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Capture FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and write qualifier; abort and timeout override every transition
    always_comb begin
        state_nxt = state;
        store_en  = (state == S_CAPTURE) && in_valid && !abort;
        case (state)
            S_IDLE:    if (start) state_nxt = ENTRY;
            S_ARM:     if (in_valid && skip_cnt == SKIP_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE: if (store_en && wr_count == LAST_WR) state_nxt = S_DONE;
            S_DONE:    if (start) state_nxt = ENTRY;
            default:   state_nxt = S_IDLE;
        endcase
        if (timeout_hit || abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Write and skip counters; both restart when a capture begins
    always_ff @(posedge clk) begin
        if (rst || cap_start) begin
            wr_count <= '0;
            skip_cnt <= '0;
        end else begin
            if (store_en) begin
                wr_count <= wr_count + 1'b1;
            end
            if ((state == S_ARM) && in_valid && !abort) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end

    // A requester that was granted last cycle still shows req; that cycle is not a new request
    always_comb begin
        grant_ok = (state == S_DONE) && !abort && !start;
        elig_a   = req_a && !gnt_a;
        elig_b   = req_b && !gnt_b;
        pick_a   = grant_ok && elig_a && (!elig_b || last_b);
        pick_b   = grant_ok && elig_b && !pick_a;
    end

    // Registered grant, storage read strobe and one-cycle-later return valid
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            stor_read  <= 1'b0;
            stor_addr  <= '0;
            last_b     <= 1'b1;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            rd_oob     <= 1'b0;
        end else begin
            gnt_a      <= pick_a;
            gnt_b      <= pick_b;
            stor_read  <= 1'b0;
            rd_valid_a <= gnt_a;
            rd_valid_b <= gnt_b;
            rd_oob     <= (gnt_a || gnt_b) && !stor_read;
            if (pick_a) begin
                stor_addr <= addr_a;
                stor_read <= ({1'b0, addr_a} < DEPTH_X);
                last_b    <= 1'b0;
            end else if (pick_b) begin
                stor_addr <= addr_b;
                stor_read <= ({1'b0, addr_b} < DEPTH_X);
                last_b    <= 1'b1;
            end
        end
    end

    assign rd_data = ((rd_valid_a || rd_valid_b) && !rd_oob) ? stor_data : '0;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Directed bench for sample_capture_ctrl: two instances (SKIP=0 and SKIP=3)
// share all stimulus; each has its own storage model.
module tb_sample_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, abort, in_valid;
    logic       req_a, req_b;
    logic [9:0] addr_a, addr_b;

    logic       store_en0, busy0, done0, timeout0, gnt_a0, gnt_b0, stor_read0, rd_valid_a0, rd_valid_b0;
    logic [9:0] wr_count0, stor_addr0;
    logic [7:0] stor_data0, rd_data0;
    logic       store_en3, busy3, done3, timeout3, gnt_a3, gnt_b3, stor_read3, rd_valid_a3, rd_valid_b3;
    logic [9:0] wr_count3, stor_addr3;
    logic [7:0] stor_data3, rd_data3;

    int checks = 0;
    int errors = 0;
    int cnt0, cnt3, vcnt, first3;

    always #5 clk = ~clk;

    sample_capture_ctrl #(.DEPTH(64), .ADDR_W(10), .DATA_W(8), .SKIP(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
        .store_en(store_en0), .wr_count(wr_count0), .busy(busy0), .done(done0), .timeout(timeout0),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a0), .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b0),
        .stor_read(stor_read0), .stor_addr(stor_addr0), .stor_data(stor_data0), .rd_data(rd_data0),
        .rd_valid_a(rd_valid_a0), .rd_valid_b(rd_valid_b0));

    sample_capture_ctrl #(.DEPTH(64), .ADDR_W(10), .DATA_W(8), .SKIP(3), .TIMEOUT(16)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
        .store_en(store_en3), .wr_count(wr_count3), .busy(busy3), .done(done3), .timeout(timeout3),
        .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a3), .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b3),
        .stor_read(stor_read3), .stor_addr(stor_addr3), .stor_data(stor_data3), .rd_data(rd_data3),
        .rd_valid_a(rd_valid_a3), .rd_valid_b(rd_valid_b3));

    // Storage contents: data[i] = i*7+3 (so data[5]=8'h26, data[10]=8'h49)
    function automatic logic [7:0] memval(input logic [9:0] a);
        return 8'(a * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            stor_data0 <= 8'h00;
            stor_data3 <= 8'h00;
        end else begin
            if (stor_read0) stor_data0 <= memval(stor_addr0);
            if (stor_read3) stor_data3 <= memval(stor_addr3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        req_a = 1'b0; req_b = 1'b0; addr_a = '0; addr_b = '0;

        // Reset: outputs zero, no store even with in_valid high
        tick(); tick();
        in_valid = 1'b1;
        #1;
        chk("rst_store_en", store_en0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_wr_count", wr_count0, 0);
        chk("rst_grants", {gnt_a0, gnt_b0, stor_read0, rd_valid_a0, rd_valid_b0, timeout0}, 0);
        chk("rst_rd_data", rd_data0, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle_store_en", store_en0, 0);

        // Capture: start, then 20 valid / 6 idle / 44 valid
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cap_busy0", busy0, 1);
        chk("cap_busy3", busy3, 1);
        cnt0 = 0; cnt3 = 0; vcnt = 0; first3 = 0;
        for (int i = 0; i < 70; i++) begin
            in_valid = (i < 20) || (i >= 26);
            #1;
            if (in_valid) vcnt++;
            if (store_en0) cnt0++;
            if (store_en3) begin
                cnt3++;
                if (first3 == 0) first3 = vcnt;
            end
            if (i == 69) begin
                chk("pre_full_done0", done0, 0);
                chk("pre_full_count0", wr_count0, 63);
            end
            tick();
        end
        chk("store_cnt0", cnt0, 64);
        chk("done0", done0, 1);
        chk("wr_count0_full", wr_count0, 64);
        chk("skip_first_store3", first3, 4);
        chk("wr_count3_partial", wr_count3, 61);

        // Three more valids: none stored by dut0, dut3 completes on its 67th
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            #1;
            if (i == 0) chk("no_store_in_done0", store_en0, 0);
            if (store_en3) cnt3++;
            tick();
        end
        in_valid = 1'b0;
        chk("store_cnt3", cnt3, 64);
        chk("done3", done3, 1);
        chk("wr_count3_full", wr_count3, 64);
        chk("wr_count0_held", wr_count0, 64);

        // Arbitration: continuous dual requests alternate A,B,A,B
        req_a = 1'b1; addr_a = 10'd5;
        req_b = 1'b1; addr_b = 10'd10;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("arb_gnt_a", gnt_a0, (k % 2 == 0));
            chk("arb_gnt_b", gnt_b0, (k % 2 == 1));
            chk("arb_stor_read", stor_read0, 1);
            chk("arb_stor_addr", stor_addr0, (k % 2 == 0) ? 5 : 10);
            if (k > 0) begin
                chk("arb_rd_valid_a", rd_valid_a0, (k % 2 == 1));
                chk("arb_rd_valid_b", rd_valid_b0, (k % 2 == 0));
                chk("arb_rd_data", rd_data0, (k % 2 == 1) ? 32'h26 : 32'h49);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("arb_tail_gnt", {gnt_a0, gnt_b0}, 0);
        chk("arb_tail_valid_b", rd_valid_b0, 1);
        chk("arb_tail_data", rd_data0, 32'h49);
        tick();
        chk("arb_quiet", {rd_valid_a0, rd_valid_b0, stor_read0}, 0);

        // Out-of-range address: granted, no storage read, data returns 0
        req_a = 1'b1; addr_a = 10'd70;
        tick();
        req_a = 1'b0;
        chk("oob_gnt_a", gnt_a0, 1);
        chk("oob_stor_read", stor_read0, 0);
        tick();
        chk("oob_rd_valid_a", rd_valid_a0, 1);
        chk("oob_rd_data", rd_data0, 0);

        // Abort from DONE, then start+abort together in IDLE stays IDLE
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_idle", {busy0, done0}, 0);
        chk("abort_wr_held", wr_count0, 64);
        req_a = 1'b1; addr_a = 10'd5;
        tick();
        req_a = 1'b0;
        chk("idle_no_grant", gnt_a0, 0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy0, done0}, 0);

        // Abort mid-capture at wr_count=30
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("recap_clear", wr_count0, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("abort_pre_count", wr_count0, 30);
        abort = 1'b1;
        #1;
        chk("abort_store_en", store_en0, 0);
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_cap_idle", busy0, 0);
        chk("abort_cap_held", wr_count0, 30);

        // Gap timeout: stop valids at wr_count=10
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        chk("to_count", wr_count0, 10);
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", {timeout0, busy0}, 2'b01);
        tick();
`ifdef CAP_TIMEOUT_EN
        chk("to_pulse", {timeout0, busy0}, 2'b10);
        chk("to_wr_held", wr_count0, 10);
        tick();
        chk("to_pulse_end", timeout0, 0);
`else
        chk("to_disabled", {timeout0, busy0}, 2'b01);
        tick();
        chk("to_still_capture", busy0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
